// File: rtl/fp_collect_pkg.sv
// Shared constants, tag/state types and the float exponent helper for the product collector.
package fp_collect_pkg;

  localparam int DATA_W_C    = 32;
  localparam int NUM_LANES_C = 16;
  localparam int LANE_W      = $clog2(NUM_LANES_C);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  typedef struct packed {
    logic save;
    logic acc_sign;
  } tag_t;

  // All-ones exponent marks NaN or Inf in IEEE-754 single precision.
  function automatic logic is_exp_max(input logic [31:0] word);
    return (word[30:23] == 8'hFF);
  endfunction

endpackage

// File: rtl/fp_tag_delay.sv
// Enabled shift register that delays the save/acc tags by the multiplier latency.
module fp_tag_delay
  import fp_collect_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  tag_t tag_i,
  output tag_t tail_o
);

  tag_t pipe_q [DEPTH];

  // Tag pipe advances in lockstep with the multiplier array.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (en_i) begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fp_product_collector.sv
// Captures saved multiplier frames into a ping-pong buffer and streams them lane by lane.
// Optional FP_NAN_FLAG_EN adds per-beat NaN/Inf (out_tuser) and per-frame (frame_nan) flags.
module fp_product_collector
  import fp_collect_pkg::*;
#(
  parameter int MUL_LATENCY = 8,
  parameter int NUM_LANES   = NUM_LANES_C,
  parameter int DATA_W      = DATA_W_C
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        mul_clken,
  input  logic                        in_save,
  input  logic                        in_acc_sign,
  input  logic [NUM_LANES*DATA_W-1:0] in_products,
  output logic                        out_tvalid,
  input  logic                        out_tready,
  output logic [DATA_W-1:0]           out_tdata,
  output logic                        out_tlast,
  output logic                        out_acc_sign,
  output logic                        stall_req,
  output logic                        frame_drop,
  output logic [7:0]                  drop_cnt
`ifdef FP_NAN_FLAG_EN
  ,
  output logic                        out_tuser,
  output logic                        frame_nan
`endif
);

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  tag_t              tail_s;
  logic              consumed_q, consumed_d;
  logic [1:0]        full_q, full_d;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        acc_q;
  logic [DATA_W-1:0] mem_q [2][NUM_LANES];
  logic              frame_drop_q;
  logic [7:0]        drop_cnt_q;
  logic              cap_cond_s, capture_s, drop_s, beat_s, last_beat_s;
  ser_state_e        state_q, state_d;
  logic [LW-1:0]     lane_q, lane_d;

  fp_tag_delay #(.DEPTH(MUL_LATENCY)) u_tag_delay (
    .clk_i  (aclk),
    .rst_i  (areset),
    .en_i   (mul_clken),
    .tag_i  ('{save: in_save, acc_sign: in_acc_sign}),
    .tail_o (tail_s)
  );

  // Capture/drop decode; writes alternate, so a full write buffer means both are full.
  always_comb begin
    cap_cond_s  = tail_s.save & ~consumed_q;
    capture_s   = cap_cond_s & ~full_q[wr_ptr_q];
    drop_s      = cap_cond_s & full_q[0] & full_q[1];
    beat_s      = out_tvalid & out_tready;
    last_beat_s = beat_s & (lane_q == LAST_LANE);
  end

  // Buffer occupancy and the once-per-tail guard; a buffer freed this cycle is not reusable yet.
  always_comb begin
    full_d = full_q;
    if (last_beat_s) begin
      full_d[rd_ptr_q] = 1'b0;
    end else begin
      full_d[rd_ptr_q] = full_q[rd_ptr_q];
    end
    if (capture_s) begin
      full_d[wr_ptr_q] = 1'b1;
    end else begin
      full_d[wr_ptr_q] = full_d[wr_ptr_q];
    end
    if (mul_clken) begin
      consumed_d = 1'b0;
    end else if (capture_s || drop_s) begin
      consumed_d = 1'b1;
    end else begin
      consumed_d = consumed_q;
    end
  end

  // Frame buffers, pointers and drop accounting.
  always_ff @(posedge aclk) begin
    if (areset) begin
      full_q       <= 2'b00;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      acc_q        <= 2'b00;
      consumed_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      drop_cnt_q   <= 8'd0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          mem_q[b][k] <= '0;
        end
      end
    end else begin
      full_q       <= full_d;
      consumed_q   <= consumed_d;
      frame_drop_q <= drop_s;
      if (capture_s) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          mem_q[wr_ptr_q][k] <= in_products[k*DATA_W +: DATA_W];
        end
        acc_q[wr_ptr_q] <= tail_s.acc_sign;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (last_beat_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (drop_s && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Serialiser state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // Serialiser next state; a full partner buffer keeps SEND for back-to-back frames.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: begin
        lane_d = '0;
        if (full_q[rd_ptr_q]) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (last_beat_s) begin
          lane_d  = '0;
          state_d = full_q[~rd_ptr_q] ? SEND : IDLE;
        end else if (beat_s) begin
          lane_d = lane_q + LW'(1);
        end else begin
          lane_d = lane_q;
        end
      end
      default: begin
        state_d = IDLE;
        lane_d  = '0;
      end
    endcase
  end

  // Stream outputs, all derived from registered state.
  always_comb begin
    out_tvalid   = 1'b0;
    out_tdata    = '0;
    out_tlast    = 1'b0;
    out_acc_sign = 1'b0;
    case (state_q)
      SEND: begin
        out_tvalid   = 1'b1;
        out_tdata    = mem_q[rd_ptr_q][lane_q];
        out_tlast    = (lane_q == LAST_LANE);
        out_acc_sign = acc_q[rd_ptr_q];
      end
      default: begin
        out_tvalid   = 1'b0;
      end
    endcase
  end

  assign stall_req  = full_q[0] & full_q[1];
  assign frame_drop = frame_drop_q;
  assign drop_cnt   = drop_cnt_q;

`ifdef FP_NAN_FLAG_EN
  logic nan_q;

  // Sticky NaN/Inf seen on accepted beats of the current frame.
  always_ff @(posedge aclk) begin
    if (areset) begin
      nan_q <= 1'b0;
    end else if (last_beat_s) begin
      nan_q <= 1'b0;
    end else if (beat_s && out_tuser) begin
      nan_q <= 1'b1;
    end
  end

  assign out_tuser = out_tvalid & is_exp_max(out_tdata);
  assign frame_nan = out_tvalid & (nan_q | out_tuser);
`endif

endmodule

// File: tb/tb_fp_product_collector.sv
// Self-checking bench: frame table plus hand sequences for stall, drop and reset corners.
module tb_fp_product_collector;
  import fp_collect_pkg::*;

  localparam int LAT = 8;
  localparam int NL  = 16;
  localparam int DW  = 32;

  logic          aclk = 1'b0;
  logic          areset, mul_clken, in_save, in_acc_sign, out_tready;
  logic [NL*DW-1:0] in_products;
  logic          out_tvalid, out_tlast, out_acc_sign, stall_req, frame_drop;
  logic [DW-1:0] out_tdata;
  logic [7:0]    drop_cnt;
`ifdef FP_NAN_FLAG_EN
  logic          out_tuser, frame_nan;
`endif

  fp_product_collector #(.MUL_LATENCY(LAT), .NUM_LANES(NL), .DATA_W(DW)) dut (
    .aclk(aclk), .areset(areset), .mul_clken(mul_clken), .in_save(in_save),
    .in_acc_sign(in_acc_sign), .in_products(in_products), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
    .out_acc_sign(out_acc_sign), .stall_req(stall_req), .frame_drop(frame_drop),
    .drop_cnt(drop_cnt)
`ifdef FP_NAN_FLAG_EN
    , .out_tuser(out_tuser), .frame_nan(frame_nan)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        acc;
    logic        user;
  } beat_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] step;
    logic        acc;
    int          nan_lane;
    int          gap;
    int          hold_lane;
    int          hold_cycles;
    logic [31:0] exp_last_word;
  } vec_t;

  beat_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          beats = 0;
  int          drop_pulses = 0;
  logic [31:0] last_word = 32'd0;
  logic        nan_sticky = 1'b0;
  vec_t        vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard monitor: a beat sampled valid&ready at negedge completes at the next posedge.
  always @(negedge aclk) begin
    if (frame_drop === 1'b1) drop_pulses++;
    if (out_tvalid === 1'b1 && out_tready === 1'b1 && areset === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        logic  exp_sticky;
        e = sb.pop_front();
        beats++;
        check("tdata", out_tdata, e.data);
        check("tlast", {31'd0, out_tlast}, {31'd0, e.last});
        check("acc_sign", {31'd0, out_acc_sign}, {31'd0, e.acc});
        exp_sticky = nan_sticky | e.user;
`ifdef FP_NAN_FLAG_EN
        check("tuser", {31'd0, out_tuser}, {31'd0, e.user});
        if (e.last) check("frame_nan", {31'd0, frame_nan}, {31'd0, exp_sticky});
`endif
        nan_sticky = e.last ? 1'b0 : exp_sticky;
        if (e.last) last_word = out_tdata;
      end
    end
  end

  function automatic logic [31:0] lane_word(input logic [31:0] base, input logic [31:0] step,
                                            input int k, input int nan_lane);
    return (k == nan_lane) ? 32'h7FC00000 : base + step * k;
  endfunction

  // Launch n saved frames on consecutive shifts; only the first npush are expected out.
  task automatic issue(input int n, input logic [31:0] base0, input logic [31:0] step,
                       input logic acc, input int gap, input int nan_lane, input int npush);
    mul_clken = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_save = 1'b1; in_acc_sign = acc; tick();
    end
    in_save = 1'b0; in_acc_sign = 1'b0;
    for (int i = 0; i < LAT - n; i++) tick();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NL; k++) begin
        logic [31:0] w;
        w = lane_word(base0 + 32'h100 * i, step, k, nan_lane);
        in_products[k*DW +: DW] = w;
        if (i < npush) sb.push_back('{data: w, last: (k == NL-1), acc: acc, user: (w[30:23] == 8'hFF)});
      end
      if (gap > 0 && i == 0) begin
        mul_clken = 1'b0;
        repeat (gap) tick();
        mul_clken = 1'b1;
      end
      tick();
    end
    in_products = '0;
  endtask

  task automatic drain(input int hold_lane, input int hold_cycles);
    int start;
    int budget;
    bit held;
    start = beats; held = 1'b0; budget = 0;
    out_tready = 1'b1;
    while (sb.size() != 0 && budget < 2000) begin
      if (hold_lane >= 0 && !held && (beats - start) == hold_lane) begin
        logic [31:0] exp_w;
        exp_w = sb[0].data;
        out_tready = 1'b0;
        for (int c = 0; c < hold_cycles; c++) begin
          @(negedge aclk);
          check("hold_tvalid", {31'd0, out_tvalid}, 32'd1);
          check("hold_tdata", out_tdata, exp_w);
          tick();
        end
        out_tready = 1'b1;
        held = 1'b1;
      end
      tick();
      budget++;
    end
    if (budget >= 2000) check("drain_timeout", sb.size(), 32'd0);
    repeat (3) tick();
    @(negedge aclk);
    check("idle_tvalid", {31'd0, out_tvalid}, 32'd0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge aclk);
    check({tag, "_tvalid"}, {31'd0, out_tvalid}, 32'd0);
    check({tag, "_tdata"}, out_tdata, 32'd0);
    check({tag, "_tlast"}, {31'd0, out_tlast}, 32'd0);
    check({tag, "_acc"}, {31'd0, out_acc_sign}, 32'd0);
    check({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
    check({tag, "_drop"}, {31'd0, frame_drop}, 32'd0);
    check({tag, "_dropcnt"}, {24'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int start, budget;
    vecs[0] = '{32'h3F800000, 32'd1, 1'b1, -1, 0, -1, 0, 32'h3F80000F};
    vecs[1] = '{32'h40000000, 32'd1, 1'b0, -1, 5, -1, 0, 32'h4000000F};
    vecs[2] = '{32'h12345600, 32'h101, 1'b1, -1, 0, 7, 10, 32'h1234650F};
    vecs[3] = '{32'h3F800000, 32'd1, 1'b0, 3, 0, -1, 0, 32'h3F80000F};
    vecs[4] = '{32'hC0000000, 32'h10000, 1'b1, -1, 0, -1, 0, 32'hC00F0000};

    areset = 1'b1; mul_clken = 1'b0; in_save = 1'b0; in_acc_sign = 1'b0;
    out_tready = 1'b0; in_products = '0;
    tick(); tick();
    check_all_zero("reset");
    tick();
    areset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      int b0;
      b0 = beats;
      out_tready = 1'b0;
      issue(1, vecs[v].base, vecs[v].step, vecs[v].acc, vecs[v].gap, vecs[v].nan_lane, 1);
      drain(vecs[v].hold_lane, vecs[v].hold_cycles);
      check("frame_beats", beats - b0, NL);
      check("frame_last_word", last_word, vecs[v].exp_last_word);
    end

    // Three frames against a stalled consumer: two buffered, one dropped.
    out_tready = 1'b0;
    drop_pulses = 0;
    start = beats;
    issue(3, 32'h50000000, 32'd1, 1'b1, 0, -1, 2);
    tick(); tick();
    @(negedge aclk);
    check("stall_req", {31'd0, stall_req}, 32'd1);
    check("drop_cnt", {24'd0, drop_cnt}, 32'd1);
    check("drop_pulses", drop_pulses, 32'd1);
    tick();
    drain(-1, 0);
    check("two_frame_beats", beats - start, 2 * NL);
    check("second_last_word", last_word, 32'h5000010F);
    check("stall_cleared", {31'd0, stall_req}, 32'd0);

    // Reset mid-frame at lane 5.
    out_tready = 1'b0;
    issue(1, 32'h60000000, 32'd1, 1'b1, 0, -1, 1);
    out_tready = 1'b1;
    start = beats; budget = 0;
    while ((beats - start) != 5 && budget < 200) begin
      tick();
      budget++;
    end
    check("reset_lane_reached", beats - start, 32'd5);
    out_tready = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    sb.delete();
    nan_sticky = 1'b0;
    check_all_zero("midreset");
    tick();

    start = beats;
    out_tready = 1'b0;
    issue(1, 32'h3F800000, 32'd1, 1'b1, 0, -1, 1);
    drain(-1, 0);
    check("post_reset_beats", beats - start, NL);
    check("post_reset_last", last_word, 32'h3F80000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_product_collector.md
Name: fp_product_collector

Overview:
- Downstream of the 16-lane fp multiplier array; consumes the 16 products (8 A/B result pairs) and the multiplier clock enable.
- Re-aligns the upstream save/accumulate tags to the multiplier pipeline latency and captures each saved 16-product frame into a 2-entry ping-pong buffer.
- Serialises each frame onto a 32-bit valid/ready stream for the summation stage, lane 0 first.

Parameters:
- MUL_LATENCY, 8: fp multiplier pipeline depth, counted in enabled (mul_clken=1) cycles; legal range 1..32.
- NUM_LANES, 16: products per frame.
- DATA_W, 32: product width, IEEE-754 single precision.

Ports:
- aclk  in  1  single clock for the whole block.
- areset  in  1  synchronous, active-high reset.
- mul_clken  in  1  the enable that drives the multiplier array; the tag pipe advances only when it is 1.
- in_save  in  1  save tag presented with the multiplier operands.
- in_acc_sign  in  1  accumulate tag presented with the operands.
- in_products  in  NUM_LANES*DATA_W  multiplier results; lane k occupies bits [k*32+31 : k*32]; lane 0 = result_1_A, lane 1 = result_1_B, and so on.
- out_tvalid  out  1  stream valid.
- out_tready  in  1  stream ready.
- out_tdata  out  DATA_W  product word.
- out_tlast  out  1  high on lane NUM_LANES-1 of each frame.
- out_acc_sign  out  1  acc tag of the frame now streaming; constant for the whole frame.
- stall_req  out  1  both buffers are full; upstream must hold mul_clken low.
- frame_drop  out  1  one-cycle pulse when a frame is lost.
- drop_cnt  out  8  saturating count of lost frames.

Behaviour:
- Reset (areset=1 at a clock edge): clears the tag pipe, both buffers, the serialiser, drop_cnt and the consumed flag. All outputs read 0. Reset asserted mid-frame abandons that frame with no tlast.
- Tag pipe:
  - MUL_LATENCY stages of {save, acc_sign}; shifts only when mul_clken=1.
  - The tail stage describes the in_products currently presented.
  - A consumed flag is set on capture and cleared on every shift, so one tail is captured at most once even while mul_clken stays 0.
- Capture: when tail.save=1, consumed=0 and a buffer is free, latch all lanes plus tail.acc_sign into the write buffer and flip the write pointer. The buffer becomes readable on the next cycle.
- Drop: a capture condition with both buffers full gives frame_drop=1 for one cycle, increments drop_cnt (saturating at 255), and sets consumed.
- stall_req is combinational on the buffer-full state. It is advisory; the block does not block the pipe itself.
- Serialiser FSM:
  - IDLE: when the read buffer is full, go to SEND with lane=0.
  - SEND:
    - out_tvalid=1; out_tdata = lane word; out_tlast = (lane == NUM_LANES-1).
    - On tvalid&tready with lane < NUM_LANES-1: lane increments.
    - On tvalid&tready on the last lane: free the buffer and flip the read pointer. If the other buffer is full, stay in SEND with lane=0 (back-to-back, no bubble); otherwise go to IDLE.
  - tdata, tlast and acc_sign stay stable while tvalid=1 and tready=0.
- Simultaneous capture and last-lane free in the same cycle: both take effect. The freed buffer is not counted as free for a capture in that same cycle.
- Latency: capture edge to first out_tvalid = 2 cycles. Ideal throughput = one frame per NUM_LANES cycles.

Optional Feature:
- Macro: FP_NAN_FLAG_EN.
- Defined:
  - Adds output out_tuser, 1 bit: high when out_tdata has exponent 0xFF (NaN or Inf).
  - Adds output frame_nan, 1 bit: sticky over the current frame, valid with tlast, cleared after the tlast handshake.
- Undefined: neither port exists; no extra logic.

Decomposition:
- Package fp_collect_pkg holds:
  - constants DATA_W_C=32, NUM_LANES_C=16, LANE_W=$clog2(NUM_LANES_C);
  - the serialiser state enum {IDLE, SEND};
  - the tag struct {save, acc_sign}.
- One sub-module, fp_tag_delay: the enabled MUL_LATENCY-deep tag shift register.

Test Plan:
1. MUL_LATENCY=8. Pulse in_save=1, in_acc_sign=1 with mul_clken always 1; present lane k = 32'h3F800000+k on the 8th shift → 16 beats of tdata 3F800000..3F80000F, tlast on beat 16, out_acc_sign=1.
2. Same as scenario 1 but mul_clken=0 for 5 cycles while the tail is saved → exactly one frame captured, no duplicate.
3. out_tready=0 for 10 cycles mid-frame at lane 7 → tdata holds lane 7, then the frame resumes at lane 8 with no loss.
4. Three saved frames on consecutive shifts, out_tready=0 → stall_req=1 after 2 captures, frame_drop pulses once, drop_cnt=1; the first two frames stream in order after tready=1.
5. areset at lane 5 of a frame → next cycle all outputs 0; a later frame streams from lane 0.
6. FP_NAN_FLAG_EN defined, lane 3 = 32'h7FC00000 → out_tuser=1 on beat 4 only; frame_nan=1 at tlast, and 0 on the next frame.
